// File: rtl/pulse_period_meter.sv
// Measures the period of a slow square wave in clk cycles, with stall timeout.
// Latency: rising edge on sig_in -> period_valid 3 clk later (3+FILT_LEN with GLITCH_FILTER_EN).
// No backpressure: period_valid is a one-cycle strobe, period holds until the next update.
// Optional feature macro: GLITCH_FILTER_EN (debounce filter between synchronizer and edge detector).
module pulse_period_meter #(
  parameter int CNT_W    = 26,
  parameter int TIMEOUT  = 50_000_000,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             measuring
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  // Last count value reached before a stall is declared.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Reject parameter sets where the counter could wrap or the filter is empty.
  if (TIMEOUT < 2 || longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_timeout
    $error("pulse_period_meter: TIMEOUT out of range for CNT_W");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("pulse_period_meter: FILT_LEN must be at least 1");
  end

  logic s1;
  logic s2;
  logic s_prev;
  logic lvl;
  logic rise;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] period_d;
  logic             valid_d;
  logic             timeout_d;

  // Two-flop synchronizer for the asynchronous input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int RUN_W = $clog2(FILT_LEN + 1);

  logic             filt;
  logic [RUN_W-1:0] run;

  // Filtered level flips only after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt <= 1'b0;
      run  <= '0;
    end else if (s2 == filt) begin
      run <= '0;
    end else if (run == RUN_W'(FILT_LEN - 1)) begin
      filt <= s2;
      run  <= '0;
    end else begin
      run <= run + RUN_W'(1);
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  // Previous-sample register for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_prev <= 1'b0;
    end else begin
      s_prev <= lvl;
    end
  end

  assign rise      = lvl & ~s_prev;
  assign measuring = (state_q == MEASURE);

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      period       <= period_d;
      period_valid <= valid_d;
      timeout      <= timeout_d;
    end
  end

  // Next-state logic: a rise in the last counting cycle still counts as a valid period.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period;
    valid_d   = 1'b0;
    timeout_d = timeout;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (rise) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d  = count_q + CNT_W'(1);
          valid_d   = 1'b1;
          count_d   = '0;
          timeout_d = 1'b0;
        end else if (count_q == CNT_LAST) begin
          state_d   = STALL;
          timeout_d = 1'b1;
          period_d  = '0;
          count_d   = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      STALL: begin
        count_d = '0;
        if (rise) begin
          // This edge starts a fresh measurement, so no period is reported.
          state_d   = MEASURE;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed waves, cycle-accurate reference model, literal spot checks.
// Model works from sig_in sample history and rise-to-rise time differences.
// Run with or without GLITCH_FILTER_EN defined.
module tb_pulse_period_meter;

  localparam int CNT_W    = 26;
  localparam int TIMEOUT  = 1000;
  localparam int FILT_LEN = 4;
  localparam int HN       = 32768;
`ifdef GLITCH_FILTER_EN
  localparam int LAT = 3 + FILT_LEN;
`else
  localparam int LAT = 3;
`endif

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             timeout;
  logic             measuring;

  int checks;
  int errors;

  pulse_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .period      (period),
    .period_valid(period_valid),
    .timeout     (timeout),
    .measuring   (measuring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit  hist [0:HN-1];   // sig_in as sampled at each clk edge
  bit  lvl_a[0:HN];     // level the edge detector sees before each edge
  int  cyc       = 0;
  int  last_rst  = 0;
  int  last_rise = 0;
  int  phase     = 0;   // 0 idle, 1 measuring, 2 stalled
  longint e_per  = 0;
  bit  e_val     = 0;
  bit  e_tmo     = 0;

  function automatic bit hv(input int k);
    return (k >= 0 && k > last_rst) ? hist[k] : 1'b0;
  endfunction

  always @(posedge clk) begin
    bit rise_m;
    bit flip;
    if (cyc < HN - 1) begin
      hist[cyc] = sig_in;
      if (!rst) begin
        last_rst     = cyc;
        lvl_a[cyc]   = 1'b0;
        lvl_a[cyc+1] = 1'b0;
        phase = 0;
        e_per = 0;
        e_val = 0;
        e_tmo = 0;
      end else begin
`ifdef GLITCH_FILTER_EN
        flip = 1'b1;
        for (int k = 2; k <= FILT_LEN + 1; k++)
          if (hv(cyc - k) == lvl_a[cyc]) flip = 1'b0;
        lvl_a[cyc+1] = flip ? ~lvl_a[cyc] : lvl_a[cyc];
`else
        flip = 1'b0;
        lvl_a[cyc] = hv(cyc - 2);
`endif
        rise_m = lvl_a[cyc] && !lvl_a[cyc-1];
        e_val  = 0;
        case (phase)
          0: if (rise_m) begin phase = 1; last_rise = cyc; end
          1: begin
            if (rise_m) begin
              e_per = cyc - last_rise;
              e_val = 1;
              e_tmo = 0;
              last_rise = cyc;
            end else if (cyc - last_rise == TIMEOUT) begin
              phase = 2;
              e_tmo = 1;
              e_per = 0;
            end
          end
          default: if (rise_m) begin phase = 1; e_tmo = 0; last_rise = cyc; end
        endcase
      end
      cyc++;
    end
  end

  // ---------------- checking ----------------
  task automatic lit(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Every cycle: outputs must match the model; while reset is low everything is 0.
  always @(negedge clk) begin
    if (!rst) begin
      lit("rst_period", period, 0);
      lit("rst_valid", period_valid, 0);
      lit("rst_timeout", timeout, 0);
      lit("rst_measuring", measuring, 0);
    end else begin
      lit("period", period, e_per);
      lit("period_valid", period_valid, e_val);
      lit("timeout", timeout, e_tmo);
      lit("measuring", measuring, phase == 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n rising edges of a square wave. Rise 0 expects r0 (-1 no check, 0 no valid);
  // later rises expect exp_per (0 means no valid pulse). Checks are LAT clk after the edge.
  task automatic wave(input int per, input int n, input int exp_per, input int r0);
    int hi;
    int ex;
    hi = per / 2;
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      if (i == 0 && r0 < 0) begin
        hold(hi);
      end else begin
        ex = (i == 0) ? r0 : exp_per;
        repeat (LAT) @(posedge clk);
        #2;
        if (ex == 0) begin
          lit("lit_no_valid", period_valid, 0);
        end else begin
          lit("lit_valid", period_valid, 1);
          lit("lit_period", period, ex);
        end
        @(posedge clk);
        #1;
        hold(hi - LAT - 1);
      end
      sig_in = 1'b0;
      hold(per - hi);
    end
  endtask

  // 400 clk wave with 2 clk high glitches at 50, 100, 150 clk into the low phase.
  task automatic gwave(input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
`ifdef GLITCH_FILTER_EN
      if (i >= 1) begin
        repeat (LAT) @(posedge clk);
        #2;
        lit("lit_glitch_valid", period_valid, 1);
        lit("lit_glitch_period", period, 400);
        @(posedge clk);
        #1;
        hold(200 - LAT - 1);
      end else begin
        hold(200);
      end
`else
      hold(200);
`endif
      sig_in = 1'b0;
      for (int g = 0; g < 3; g++) begin
        hold(g == 0 ? 50 : 48);
        sig_in = 1'b1;
        hold(2);
        sig_in = 1'b0;
      end
      hold(48);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    sig_in = 1'b0;

    // 1. reset held while the input toggles
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      sig_in = 1'b1;
      hold(5);
      sig_in = 1'b0;
      hold(5);
    end
    rst = 1'b1;
    hold(20);

    // 2. 200 clk wave, then 350 clk wave
    wave(200, 4, 200, 0);
    wave(350, 3, 350, 200);

    // 3. stall, then recovery
    hold(1100);
    lit("lit_stall_timeout", timeout, 1);
    lit("lit_stall_period", period, 0);
    wave(200, 3, 200, 0);
    lit("lit_recovered_timeout", timeout, 0);

    // 4. edges exactly TIMEOUT apart, then one clk too far apart
    wave(1000, 3, 1000, 200);
    lit("lit_boundary_timeout", timeout, 0);
    wave(1001, 3, 0, 1000);
    hold(600);
    lit("lit_late_timeout", timeout, 1);

    // 5. asynchronous reset 120 clk into a measurement
    wave(200, 2, 200, 0);
    sig_in = 1'b1;
    hold(100);
    sig_in = 1'b0;
    hold(20);
    #2;
    rst = 1'b0;
    #1;
    lit("lit_arst_period", period, 0);
    lit("lit_arst_valid", period_valid, 0);
    lit("lit_arst_timeout", timeout, 0);
    lit("lit_arst_measuring", measuring, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    hold(50);
    wave(200, 3, 200, 0);

    // 6. glitchy 400 clk wave
    gwave(4);
`ifdef GLITCH_FILTER_EN
    lit("lit_glitch_final_period", period, 400);
`else
    lit("lit_glitch_short_period", period <= 50, 1);
`endif
    hold(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
